// File: rtl/scaler_v_ctrl_if.sv
// Config and pixel-stream bundle around scaler_v_ctrl.
// master = software/source side, slave = the controller.
interface scaler_v_ctrl_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic                   cfg_en;
  logic                   cfg_wr;
  logic [15:0]            cfg_line_in_size;
  logic [15:0]            cfg_scale_step;
  logic [PIXEL_WIDTH-1:0] di_i;
  logic                   de_i;
  logic                   hs_i;
  logic                   vs_i;
  logic [PIXEL_WIDTH-1:0] do_o;
  logic                   de_o;
  logic                   hs_o;
  logic                   vs_o;
  logic [15:0]            line_in_size;
  logic [15:0]            scale_step;
  logic                   upd_o;
  logic                   err_cfg;
  logic                   busy;
  logic [15:0]            frame_cnt;
  logic [15:0]            line_cnt;

  modport master (
    output cfg_en, cfg_wr, cfg_line_in_size, cfg_scale_step,
    output di_i, de_i, hs_i, vs_i,
    input  do_o, de_o, hs_o, vs_o,
    input  line_in_size, scale_step, upd_o, err_cfg, busy,
    input  frame_cnt, line_cnt
  );

  modport slave (
    input  cfg_en, cfg_wr, cfg_line_in_size, cfg_scale_step,
    input  di_i, de_i, hs_i, vs_i,
    output do_o, de_o, hs_o, vs_o,
    output line_in_size, scale_step, upd_o, err_cfg, busy,
    output frame_cnt, line_cnt
  );
endinterface

// File: rtl/scaler_v_ctrl.sv
// Frame-synchronous config apply and whole-frame stream admission
// in front of scaler_v.
module scaler_v_ctrl #(
  parameter int LINE_IN_SIZE_MAX = 1024,
  parameter int LINE_STEP        = 4096,
  parameter int PIXEL_WIDTH      = 8,
  parameter int STEP_MIN         = 1024
) (
  input logic            clk,
  input logic            rst,
  scaler_v_ctrl_if.slave bus
);

  localparam logic [16:0] LMAX     = 17'(LINE_IN_SIZE_MAX);
  localparam logic [16:0] SMIN     = 17'(STEP_MIN);
  localparam logic [16:0] SMAX     = 17'(4 * LINE_STEP);
  localparam logic [15:0] STEP_RST = 16'(LINE_STEP);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [PIXEL_WIDTH-1:0] do_q, do_d;
  logic                   de_q, de_d;
  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic [15:0]            act_line_q, act_line_d;
  logic [15:0]            act_step_q, act_step_d;
  logic [15:0]            pend_line_q, pend_line_d;
  logic [15:0]            pend_step_q, pend_step_d;
  logic                   pend_q, pend_d;
  logic                   loaded_q, loaded_d;
  logic                   upd_q, upd_d;
  logic                   err_q, err_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic [15:0]            line_cnt_q, line_cnt_d;
  logic                   cfg_ok;
  logic                   admit;

  always_comb begin
    state_d     = state_q;
    admit       = 1'b0;
    act_line_d  = act_line_q;
    act_step_d  = act_step_q;
    pend_line_d = pend_line_q;
    pend_step_d = pend_step_q;
    pend_d      = pend_q;
    loaded_d    = loaded_q;
    upd_d       = 1'b0;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    line_cnt_d  = line_cnt_q;

    cfg_ok = ({1'b0, bus.cfg_line_in_size} < LMAX)
          && ({1'b0, bus.cfg_scale_step} >= SMIN)
          && ({1'b0, bus.cfg_scale_step} <= SMAX);

    unique case (state_q)
      IDLE: begin
        if (bus.cfg_en && (pend_q || loaded_q))
          state_d = WAIT_VS;
      end
      WAIT_VS: begin
        if (!bus.cfg_en) begin
          state_d = IDLE;
        end else if (bus.vs_i) begin
          state_d = RUN;
          admit   = 1'b1;
        end
      end
      RUN: begin
        // A stop request takes effect only on the next frame start.
        if (bus.vs_i && !bus.cfg_en)
          state_d = IDLE;
        else
          admit = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    do_d = (admit && bus.de_i) ? bus.di_i : '0;
    de_d = admit & bus.de_i;
    hs_d = admit & bus.hs_i;
    vs_d = admit & bus.vs_i;

    if (admit && bus.vs_i) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      line_cnt_d  = 16'd1;
      if (pend_q) begin
        act_line_d = pend_line_q;
        act_step_d = pend_step_q;
        pend_d     = 1'b0;
        loaded_d   = 1'b1;
        upd_d      = 1'b1;
      end
    end else if (admit && bus.hs_i && (line_cnt_q != 16'hFFFF)) begin
      line_cnt_d = line_cnt_q + 16'd1;
    end

    // Evaluated after apply so a write on the vs cycle targets the next frame.
    if (bus.cfg_wr) begin
      if (cfg_ok) begin
        pend_line_d = bus.cfg_line_in_size;
        pend_step_d = bus.cfg_scale_step;
        pend_d      = 1'b1;
        err_d       = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      do_q        <= '0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      act_line_q  <= 16'd0;
      act_step_q  <= STEP_RST;
      pend_line_q <= 16'd0;
      pend_step_q <= STEP_RST;
      pend_q      <= 1'b0;
      loaded_q    <= 1'b0;
      upd_q       <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
      line_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      do_q        <= do_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      act_line_q  <= act_line_d;
      act_step_q  <= act_step_d;
      pend_line_q <= pend_line_d;
      pend_step_q <= pend_step_d;
      pend_q      <= pend_d;
      loaded_q    <= loaded_d;
      upd_q       <= upd_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  assign bus.do_o         = do_q;
  assign bus.de_o         = de_q;
  assign bus.hs_o         = hs_q;
  assign bus.vs_o         = vs_q;
  assign bus.line_in_size = act_line_q;
  assign bus.scale_step   = act_step_q;
  assign bus.upd_o        = upd_q;
  assign bus.err_cfg      = err_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.frame_cnt    = frame_cnt_q;
  assign bus.line_cnt     = line_cnt_q;

endmodule

// File: tb/tb_scaler_v_ctrl.sv
// Self-checking bench for scaler_v_ctrl: vector table, directed
// corner sequences and randomized traffic against a frame-level model.
module tb_scaler_v_ctrl;

  logic clk;
  logic rst;

  scaler_v_ctrl_if #(.PIXEL_WIDTH(8)) bus ();

  scaler_v_ctrl #(
    .LINE_IN_SIZE_MAX(1024),
    .LINE_STEP       (4096),
    .PIXEL_WIDTH     (8),
    .STEP_MIN        (1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 stopped, 1 armed for a frame, 2 streaming.
  int          m_phase;
  bit          m_adm, m_ok;
  bit          p_has, a_has;
  logic [15:0] p_line, p_step, a_line, a_step;
  logic [7:0]  m_do;
  bit          m_de, m_hs, m_vs, m_upd, m_err;
  logic [15:0] m_fc, m_lc;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; p_has = 0; a_has = 0;
      p_line = 0; p_step = 4096; a_line = 0; a_step = 4096;
      m_do = 0; m_de = 0; m_hs = 0; m_vs = 0; m_upd = 0; m_err = 0;
      m_fc = 0; m_lc = 0;
    end else begin
      m_ok = (int'(bus.cfg_line_in_size) < 1024)
          && (int'(bus.cfg_scale_step) >= 1024)
          && (int'(bus.cfg_scale_step) <= 4 * 4096);
      m_adm = 0;
      if (m_phase == 2) m_adm = !(bus.vs_i && !bus.cfg_en);
      if (m_phase == 1) m_adm = bus.vs_i && bus.cfg_en;
      case (m_phase)
        0: if (bus.cfg_en && (p_has || a_has)) m_phase = 1;
        1: if (!bus.cfg_en) m_phase = 0;
           else if (bus.vs_i) m_phase = 2;
        default: if (bus.vs_i && !bus.cfg_en) m_phase = 0;
      endcase
      m_de  = m_adm && bus.de_i;
      m_hs  = m_adm && bus.hs_i;
      m_vs  = m_adm && bus.vs_i;
      m_do  = m_de ? bus.di_i : 8'd0;
      m_upd = 0;
      if (m_vs) begin
        m_fc = m_fc + 1;
        m_lc = 1;
        if (p_has) begin
          a_line = p_line; a_step = p_step;
          a_has = 1; p_has = 0; m_upd = 1;
        end
      end else if (m_hs && m_lc != 16'hFFFF) begin
        m_lc = m_lc + 1;
      end
      if (bus.cfg_wr) begin
        if (m_ok) begin
          p_line = bus.cfg_line_in_size; p_step = bus.cfg_scale_step;
          p_has = 1; m_err = 0;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_do",   bus.do_o,         m_do);
      chk("m_de",   bus.de_o,         m_de);
      chk("m_hs",   bus.hs_o,         m_hs);
      chk("m_vs",   bus.vs_o,         m_vs);
      chk("m_line", bus.line_in_size, a_line);
      chk("m_step", bus.scale_step,   a_step);
      chk("m_upd",  bus.upd_o,        m_upd);
      chk("m_err",  bus.err_cfg,      m_err);
      chk("m_busy", bus.busy,         m_phase != 0);
      chk("m_fcnt", bus.frame_cnt,    m_fc);
      chk("m_lcnt", bus.line_cnt,     m_lc);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic px(input bit v, input bit h, input bit e,
                    input logic [7:0] d);
    bus.vs_i = v; bus.hs_i = h; bus.de_i = e; bus.di_i = d;
    @(posedge clk);
    #1;
    bus.vs_i = 0; bus.hs_i = 0; bus.de_i = 0; bus.di_i = 0;
    bus.cfg_wr = 0;
  endtask

  task automatic wr(input logic [15:0] l, input logic [15:0] s);
    bus.cfg_wr = 1; bus.cfg_line_in_size = l; bus.cfg_scale_step = s;
    @(posedge clk);
    #1;
    bus.cfg_wr = 0;
  endtask

  task automatic line(input int np, input bit v, input bit rnd);
    for (int p = 0; p < np; p++) begin
      if (rnd) begin
        if ($urandom_range(0, 39) == 0) begin
          bus.cfg_wr = 1;
          bus.cfg_line_in_size = 16'($urandom_range(0, 1100));
          bus.cfg_scale_step = 16'($urandom_range(900, 17000));
        end
        if ($urandom_range(0, 149) == 0) bus.cfg_en = ~bus.cfg_en;
      end
      px(v && p == 0, p == 0, rnd ? ($urandom_range(0, 3) != 0) : 1'b1,
         8'($urandom));
    end
    idle(2);
  endtask

  typedef struct {
    logic [15:0] line;
    logic [15:0] step;
    bit          err;
    bit          upd;
    logic [15:0] a_line;
    logic [15:0] a_step;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{16'd255,  16'd8192,  1'b0, 1'b1, 16'd255,  16'd8192};
    tbl[1] = '{16'd1024, 16'd4096,  1'b1, 1'b0, 16'd255,  16'd8192};
    tbl[2] = '{16'd100,  16'd512,   1'b1, 1'b0, 16'd255,  16'd8192};
    tbl[3] = '{16'd1023, 16'd16384, 1'b0, 1'b1, 16'd1023, 16'd16384};
    tbl[4] = '{16'd0,    16'd1024,  1'b0, 1'b1, 16'd0,    16'd1024};
    tbl[5] = '{16'd10,   16'd16385, 1'b1, 1'b0, 16'd0,    16'd1024};
    tbl[6] = '{16'd10,   16'd1023,  1'b1, 1'b0, 16'd0,    16'd1024};
    tbl[7] = '{16'd255,  16'd4096,  1'b0, 1'b1, 16'd255,  16'd4096};

    rst = 1; bus.cfg_en = 0; bus.cfg_wr = 0;
    bus.cfg_line_in_size = 0; bus.cfg_scale_step = 0;
    bus.di_i = 0; bus.de_i = 0; bus.hs_i = 0; bus.vs_i = 0;
    idle(1);
    chk_en = 1;
    idle(1);
    chk("rst_de",   bus.de_o,         0);
    chk("rst_step", bus.scale_step,   4096);
    chk("rst_line", bus.line_in_size, 0);
    chk("rst_busy", bus.busy,         0);
    chk("rst_fcnt", bus.frame_cnt,    0);
    rst = 0;

    // Nothing forwarded while stopped with no config.
    line(8, 1, 0);
    chk("idle_fcnt", bus.frame_cnt, 0);

    bus.cfg_en = 1;
    foreach (tbl[i]) begin
      wr(tbl[i].line, tbl[i].step);
      idle(2);
      chk("tbl_err", bus.err_cfg, tbl[i].err);
      px(1, 1, 1, 8'h5A);
      chk("tbl_upd",  bus.upd_o,        tbl[i].upd);
      chk("tbl_line", bus.line_in_size, tbl[i].a_line);
      chk("tbl_step", bus.scale_step,   tbl[i].a_step);
      chk("tbl_fcnt", bus.frame_cnt,    16'(i + 1));
      idle(2);
    end

    // Two full 4x256 frames with 255/8192.
    wr(255, 8192);
    for (int f = 0; f < 2; f++)
      for (int l = 0; l < 4; l++) line(256, l == 0, 0);
    chk("f2_fcnt", bus.frame_cnt,    10);
    chk("f2_lcnt", bus.line_cnt,     4);
    chk("f2_step", bus.scale_step,   8192);
    chk("f2_line", bus.line_in_size, 255);

    // Mid-frame write waits for the next frame start.
    line(256, 1, 0);
    bus.cfg_wr = 1; bus.cfg_line_in_size = 255; bus.cfg_scale_step = 4096;
    for (int l = 1; l < 4; l++) line(256, 0, 0);
    chk("mid_step_hold", bus.scale_step, 8192);
    px(1, 1, 1, 8'h11);
    chk("mid_upd",  bus.upd_o,      1);
    chk("mid_step", bus.scale_step, 4096);
    chk("mid_fcnt", bus.frame_cnt,  12);
    for (int l = 1; l < 4; l++) line(64, 0, 0);

    // Write coinciding with vs goes to the following frame.
    wr(255, 8192);
    bus.cfg_wr = 1; bus.cfg_line_in_size = 255; bus.cfg_scale_step = 6144;
    px(1, 1, 1, 8'h22);
    chk("same_upd0",  bus.upd_o,      1);
    chk("same_step0", bus.scale_step, 8192);
    for (int l = 1; l < 4; l++) line(16, 0, 0);
    px(1, 1, 1, 8'h33);
    chk("same_upd1",  bus.upd_o,      1);
    chk("same_step1", bus.scale_step, 6144);
    chk("same_fcnt",  bus.frame_cnt,  14);
    for (int l = 1; l < 4; l++) line(16, 0, 0);

    // Stop request mid-frame: frame completes, next vs is dropped.
    line(20, 1, 0);
    line(20, 0, 0);
    bus.cfg_en = 0;
    line(20, 0, 0);
    line(20, 0, 0);
    chk("stop_busy_run", bus.busy,     1);
    chk("stop_lcnt",     bus.line_cnt, 4);
    px(1, 1, 1, 8'h44);
    chk("stop_vs",   bus.vs_o,      0);
    chk("stop_de",   bus.de_o,      0);
    chk("stop_busy", bus.busy,      0);
    chk("stop_fcnt", bus.frame_cnt, 15);

    // Enable mid-frame: partial frame dropped, next one admitted.
    bus.cfg_en = 1;
    idle(1);
    px(0, 1, 1, 8'h55);
    chk("late_de",   bus.de_o,     0);
    chk("late_lcnt", bus.line_cnt, 4);
    for (int l = 0; l < 2; l++) line(20, 0, 0);
    px(1, 1, 1, 8'h3C);
    chk("late_vs",   bus.vs_o,      1);
    chk("late_do",   bus.do_o,      8'h3C);
    chk("late_lcnt1", bus.line_cnt, 1);
    chk("late_fcnt", bus.frame_cnt, 16);
    for (int l = 1; l < 4; l++) line(20, 0, 0);

    // Randomized traffic, model checks every cycle.
    for (int f = 0; f < 60; f++) begin
      int nl;
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++)
        line($urandom_range(3, 20), l == 0 && $urandom_range(0, 7) != 0, 1);
    end

    // Reset in the middle of an admitted line.
    bus.cfg_en = 1;
    wr(255, 8192);
    idle(2);
    px(1, 1, 1, 8'h66);
    px(0, 0, 1, 8'h67);
    rst = 1;
    px(0, 0, 1, 8'h68);
    chk("mrst_de",   bus.de_o,         0);
    chk("mrst_step", bus.scale_step,   4096);
    chk("mrst_line", bus.line_in_size, 0);
    chk("mrst_fcnt", bus.frame_cnt,    0);
    chk("mrst_lcnt", bus.line_cnt,     0);
    chk("mrst_busy", bus.busy,         0);
    chk("mrst_err",  bus.err_cfg,      0);
    rst = 0;
    px(0, 0, 1, 8'h69);
    chk("mrst_de2", bus.de_o, 0);
    idle(2);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/scaler_v_ctrl.md
Name: scaler_v_ctrl

Overview:
Frame-synchronous configuration and stream-admission controller placed in front of scaler_v. Software-side writes of line size and vertical scale step are accepted at any time, validated, held as pending, and applied only at a frame-start pulse, so scaler_v never sees a mid-frame parameter change. The block also gates the pixel stream: whole frames only, from the first frame-start after enable. It keeps frame and line statistics.

Parameters:
LINE_IN_SIZE_MAX, 1024, maximum line length supported by the downstream scaler_v line buffer
LINE_STEP, 4096, fixed-point unity step (scale 1.0)
PIXEL_WIDTH, 8, pixel data width
STEP_MIN, 1024, smallest legal scale_step (maximum upscale LINE_STEP/STEP_MIN = 4x)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_en  in  1  level: 1 = run, 0 = stop at next frame boundary
cfg_wr  in  1  one-cycle write strobe for cfg_line_in_size/cfg_scale_step
cfg_line_in_size  in  16  pixels per line minus 1
cfg_scale_step  in  16  vertical step, LINE_STEP units
di_i  in  PIXEL_WIDTH  pixel in
de_i  in  1  pixel valid
hs_i  in  1  line-start pulse (1 cycle)
vs_i  in  1  frame-start pulse (1 cycle, coincides with the first hs_i)
do_o  out  PIXEL_WIDTH  pixel to scaler_v
de_o / hs_o / vs_o  out  1 each  gated strobes to scaler_v
line_in_size  out  16  active value to scaler_v
scale_step  out  16  active value to scaler_v
upd_o  out  1  one-cycle pulse: active config replaced
err_cfg  out  1  sticky: last write rejected
busy  out  1  state != IDLE
frame_cnt  out  16  admitted frames, wraps 0xFFFF->0
line_cnt  out  16  hs pulses in the current admitted frame

Behaviour:
- Reset values: do_o=0, de_o/hs_o/vs_o=0, line_in_size=0, scale_step=LINE_STEP, upd_o=0, err_cfg=0, busy=0, frame_cnt=0, line_cnt=0, pending flag=0, state=IDLE. Reset mid-frame aborts immediately; no further strobes are forwarded.
- Config write: a write is valid when cfg_line_in_size < LINE_IN_SIZE_MAX and STEP_MIN <= cfg_scale_step <= 4*LINE_STEP.
  - Valid write: load the pending registers, set pending, clear err_cfg.
  - Invalid write: pending registers and flag unchanged, err_cfg=1.
  - Later writes overwrite pending; the last write before a vs_i pulse wins.
- Apply: on a vs_i cycle, if pending=1 and the frame is admitted, copy pending to active and clear pending. upd_o=1 in the following cycle, aligned with vs_o. cfg_wr in the same cycle as vs_i does not affect that frame; it becomes pending for the next frame.
- FSM:
  - IDLE: nothing forwarded. Go to WAIT_VS when cfg_en=1 and (pending or an active config has ever been loaded).
  - WAIT_VS: nothing forwarded. On vs_i go to RUN; that frame is admitted, including its vs_i cycle. If cfg_en drops, go to IDLE.
  - RUN: forward all strobes. On vs_i with cfg_en=0, go to IDLE and do not forward that vs_i; the frame in progress has already completed.
- Stream path: 1-cycle registered pass-through. do_o/de_o/hs_o/vs_o equal the inputs delayed 1 clk when admitted, else 0. do_o is 0 when de_o=0.
- Counters:
  - frame_cnt increments on each admitted vs_i.
  - line_cnt is set to 1 on an admitted vs_i, incremented on other admitted hs_i, saturates at 0xFFFF, and holds its value in IDLE/WAIT_VS.
- Outputs line_in_size/scale_step change only in the cycle after an admitted vs_i. They are stable for the whole frame as seen by scaler_v.

Test Plan:
- Reset, write line_in_size=255/step=8192, cfg_en=1, send 2 frames of 4 lines x 256 px -> no output until the first vs_i; upd_o once, 1 clk after vs_i; line_in_size=255, scale_step=8192; frame_cnt=2; line_cnt=4; output equals input delayed 1 clk.
- Enable, then start mid-frame (line 2 of 4 before the first vs_i) -> lines 2-4 dropped (de_o=0); the next full frame is forwarded intact.
- During a RUN frame write step=4096 at line 2 -> scale_step stays 8192 until the next vs_i; it changes to 4096 at vs_o of the following frame with upd_o=1.
- Write line_in_size=1024 then step=512 -> err_cfg=1 after each write, active and pending unchanged; a subsequent valid write (255/4096) clears err_cfg.
- cfg_wr (step=6144) in the same cycle as vs_i with step=8192 pending -> this frame uses 8192, the next frame uses 6144; upd_o pulses at both frames.
- Drop cfg_en mid-frame -> current frame completes fully, the next vs_i is not forwarded, busy=0. Assert rst mid-line -> de_o=0 the next cycle, all outputs at reset values.
